mack_decoder_v3: RTL

MACK_DECODER_V3 -- requirements
Module: mack_decoder_v3

---
 rtl/mack_decoder_v3.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mack_decoder_v3.sv
// Address decoder and bus-cycle controller for a 68000-style board:
// ROM overlay at boot, chip enables, wait-state DTACK generation and
// bus-error timeout.
module mack_decoder_v3 #(
   parameter int unsigned BOOT_CYCLES  = 8,
   parameter logic [8:0]  ROM_BASE     = 9'h070,
   parameter logic [8:0]  DUART_BASE   = 9'h078,
   parameter logic [8:0]  EXP_BASE     = 9'h080,
   parameter logic [8:0]  REGION_MASK  = 9'h1F8,
   parameter int unsigned ROM_WS       = 0,
   parameter int unsigned RAM_WS       = 0,
   parameter int unsigned BERR_TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [23:15] ADDR,
   input  logic        AS,
   input  logic        IACK,
   input  logic        DTACK_IN,
   input  logic        EXP_DTACK_IN,
   output logic        ROMEN,
   output logic        RAMEN,
   output logic        DUARTEN,
   output logic        EXPEN,
   output logic        DTACK,
   output logic        BERR,
   output logic        BOOT
);

   localparam logic [3:0] BootLimit = 4'(BOOT_CYCLES);
   localparam logic [3:0] RomWs     = 4'(ROM_WS);
   localparam logic [3:0] RamWs     = 4'(RAM_WS);
   localparam logic [7:0] TmoLimit  = 8'(BERR_TIMEOUT);
   localparam logic       TmoEnable = (BERR_TIMEOUT != 0);

   logic       boot_q;
   logic [3:0] boot_cnt_q;
   logic       edge_q;
   logic [3:0] wait_q;
   logic [7:0] tmo_q;
   logic       berr_q;

   logic [8:0] masked;
   logic       hit_rom, hit_duart, hit_exp;
   logic       sel_rom, sel_duart, sel_exp, sel_ram;
   logic       dtack_c;
   logic       berr_hit;

   assign masked    = ADDR & REGION_MASK;
   assign hit_rom   = (masked == ROM_BASE);
   assign hit_duart = (masked == DUART_BASE);
   assign hit_exp   = (masked == EXP_BASE);

   // Before the overlay ends everything maps to ROM so the reset vectors come from it.
   assign sel_rom   = !boot_q || hit_rom;
   assign sel_duart = boot_q && !hit_rom && hit_duart;
   assign sel_exp   = boot_q && !hit_rom && !hit_duart && hit_exp;
   assign sel_ram   = boot_q && !hit_rom && !hit_duart && !hit_exp;

   // Chip enables and DTACK, all active-low and idle outside a live bus cycle.
   always_comb begin
      ROMEN   = 1'b1;
      RAMEN   = 1'b1;
      DUARTEN = 1'b1;
      EXPEN   = 1'b1;
      dtack_c = 1'b1;
      if (!RST && !AS) begin
         if (!IACK) begin
            dtack_c = DTACK_IN;
         end else if (sel_rom) begin
            ROMEN   = 1'b0;
            dtack_c = !(wait_q >= RomWs);
         end else if (sel_duart) begin
            DUARTEN = 1'b0;
            dtack_c = DTACK_IN;
         end else if (sel_exp) begin
            EXPEN   = 1'b0;
            dtack_c = EXP_DTACK_IN;
         end else if (sel_ram) begin
            RAMEN   = 1'b0;
            dtack_c = !(wait_q >= RamWs);
         end
      end
   end

   // A DTACK arriving on the timeout clock suppresses the bus error.
   assign berr_hit = TmoEnable && !RST && !AS && (tmo_q == TmoLimit) && dtack_c;

   assign DTACK = dtack_c;
   assign BERR  = !(berr_q || berr_hit);
   assign BOOT  = boot_q;

   // Overlay tracking: count AS falls, end the overlay only between bus cycles.
   always_ff @(posedge CLK) begin
      if (RST) begin
         boot_q     <= 1'b0;
         boot_cnt_q <= 4'd0;
         edge_q     <= 1'b0;
      end else begin
         edge_q <= !AS;
         if (!AS && !edge_q && !boot_q && (boot_cnt_q != 4'hF)) begin
            boot_cnt_q <= boot_cnt_q + 4'd1;
         end
         if (AS && !boot_q && (boot_cnt_q >= BootLimit)) begin
            boot_q <= 1'b1;
         end
      end
   end

   // Wait-state counter, saturating at 15.
   always_ff @(posedge CLK) begin
      if (RST || AS) begin
         wait_q <= 4'd0;
      end else if (wait_q != 4'hF) begin
         wait_q <= wait_q + 4'd1;
      end
   end

   // Timeout counter advances only while the cycle is still unacknowledged.
   always_ff @(posedge CLK) begin
      if (RST || AS) begin
         tmo_q <= 8'd0;
      end else if (dtack_c && (tmo_q != 8'hFF)) begin
         tmo_q <= tmo_q + 8'd1;
      end
   end

   // Bus error latch: held until the clock after AS returns high.
   always_ff @(posedge CLK) begin
      if (RST || AS) begin
         berr_q <= 1'b0;
      end else begin
         berr_q <= berr_q || berr_hit;
      end
   end

endmodule
